// File: rtl/nv_blkbox_sink_misr_if.sv
// Sink bus: absorbed data/qualifiers in, observability state out.
interface nv_blkbox_sink_misr_if #(
  parameter int unsigned CHANNELS  = 4,
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned SIG_WIDTH = 32,
  parameter int unsigned CNT_WIDTH = 16
);
  logic [CHANNELS*WIDTH-1:0] sink_data;
  logic [CHANNELS-1:0]       sink_vld;
  logic                      sink_en;
  logic                      sink_clr;
  logic [SIG_WIDTH-1:0]      sig_out;
  logic [CHANNELS-1:0]       toggle_seen;
  logic [CNT_WIDTH-1:0]      vld_cnt;

  // Producer side: drives the dead-ended nets, may watch the results.
  modport master (
    output sink_data, sink_vld, sink_en, sink_clr,
    input  sig_out, toggle_seen, vld_cnt
  );

  // Sink cell side.
  modport slave (
    input  sink_data, sink_vld, sink_en, sink_clr,
    output sig_out, toggle_seen, vld_cnt
  );
endinterface

// File: rtl/nv_blkbox_sink_misr.sv
// Observable tie-off sink: folds unused nets into a MISR signature, tracks
// per-channel toggle activity and counts valid update cycles.
module nv_blkbox_sink_misr #(
  parameter int unsigned          CHANNELS  = 4,
  parameter int unsigned          WIDTH     = 32,
  parameter int unsigned          SIG_WIDTH = 32,
  parameter logic [SIG_WIDTH-1:0] POLY      = SIG_WIDTH'(32'h04C11DB7),
  parameter int unsigned          CNT_WIDTH = 16
) (
  input logic                  nvdla_core_clk,
  input logic                  nvdla_core_rst,
  nv_blkbox_sink_misr_if.slave sink
);

  localparam int unsigned NCHUNK = (WIDTH + SIG_WIDTH - 1) / SIG_WIDTH;
  localparam int unsigned PADW   = NCHUNK * SIG_WIDTH;

  logic [SIG_WIDTH-1:0]             r_sig;
  logic [CHANNELS-1:0]              r_toggle;
  logic [CNT_WIDTH-1:0]             r_cnt;
  logic [CHANNELS-1:0][WIDTH-1:0]   r_prev_data;
  logic [CHANNELS-1:0]              r_prev_vld;

  logic [SIG_WIDTH-1:0]             w_fold;
  logic [SIG_WIDTH-1:0]             w_sig_next;
  logic [PADW-1:0]                  w_pad;

  // XOR all SIG_WIDTH-bit chunks of every valid channel; invalid data never enters.
  always_comb begin
    w_fold = '0;
    w_pad  = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      w_pad            = '0;
      w_pad[WIDTH-1:0] = sink.sink_data[c*WIDTH +: WIDTH];
      if (sink.sink_vld[c]) begin
        for (int unsigned k = 0; k < NCHUNK; k++) begin
          w_fold = w_fold ^ w_pad[k*SIG_WIDTH +: SIG_WIDTH];
        end
      end
    end
  end

  // Galois-style MISR step; advances every enabled cycle, even with fold=0.
  always_comb begin
    w_sig_next = {r_sig[SIG_WIDTH-2:0], 1'b0}
               ^ (r_sig[SIG_WIDTH-1] ? POLY : SIG_WIDTH'(0))
               ^ w_fold;
  end

  // State update: clear beats enable; disabled cycles hold everything.
  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      r_sig       <= '0;
      r_toggle    <= '0;
      r_cnt       <= '0;
      r_prev_data <= '0;
      r_prev_vld  <= '0;
    end else if (sink.sink_clr) begin
      r_sig       <= '0;
      r_toggle    <= '0;
      r_cnt       <= '0;
      r_prev_data <= '0;
      r_prev_vld  <= '0;
    end else if (sink.sink_en) begin
      r_sig <= w_sig_next;
      if ((|sink.sink_vld) && (r_cnt != {CNT_WIDTH{1'b1}})) begin
        r_cnt <= r_cnt + CNT_WIDTH'(1);
      end
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        if (sink.sink_vld[c]) begin
          if (r_prev_vld[c] && (sink.sink_data[c*WIDTH +: WIDTH] != r_prev_data[c])) begin
            r_toggle[c] <= 1'b1;
          end
          r_prev_data[c] <= sink.sink_data[c*WIDTH +: WIDTH];
          r_prev_vld[c]  <= 1'b1;
        end
      end
    end
  end

  assign sink.sig_out     = r_sig;
  assign sink.toggle_seen = r_toggle;
  assign sink.vld_cnt     = r_cnt;

endmodule

// File: tb/tb_nv_blkbox_sink_misr.sv
// Self-checking bench for nv_blkbox_sink_misr: directed scenarios plus a
// randomized run, checked against a behavioural model of the sink rules.
module tb_nv_blkbox_sink_misr;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  nv_blkbox_sink_misr_if #(.CHANNELS(2), .WIDTH(8),  .SIG_WIDTH(8), .CNT_WIDTH(4)) bus ();
  nv_blkbox_sink_misr_if #(.CHANNELS(2), .WIDTH(16), .SIG_WIDTH(8), .CNT_WIDTH(4)) bus16 ();

  nv_blkbox_sink_misr #(
    .CHANNELS(2), .WIDTH(8), .SIG_WIDTH(8), .POLY(8'h1D), .CNT_WIDTH(4)
  ) dut (
    .nvdla_core_clk(clk),
    .nvdla_core_rst(rst),
    .sink          (bus)
  );

  nv_blkbox_sink_misr #(
    .CHANNELS(2), .WIDTH(16), .SIG_WIDTH(8), .POLY(8'h1D), .CNT_WIDTH(4)
  ) dut16 (
    .nvdla_core_clk(clk),
    .nvdla_core_rst(rst),
    .sink          (bus16)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Behavioural model state
  int         m_sig;
  int         m_cnt;
  bit [1:0]   m_tog;
  int         m_prev [2];
  bit [1:0]   m_have;

  task automatic m_reset();
    m_sig  = 0;
    m_cnt  = 0;
    m_tog  = '0;
    m_prev[0] = 0;
    m_prev[1] = 0;
    m_have = '0;
  endtask

  // One clock edge of the sink, computed from the textual rules.
  task automatic m_update(input logic en, input logic clr, input logic [1:0] vld,
                          input logic [15:0] d);
    int fold;
    int byte_v;
    if (clr) begin
      m_reset();
    end else if (en) begin
      fold = 0;
      for (int c = 0; c < 2; c++) begin
        if (vld[c]) begin
          byte_v = int'(d[c*8 +: 8]);
          fold   = fold ^ byte_v;
        end
      end
      m_sig = ((m_sig * 2) % 256) ^ ((m_sig >= 128) ? 'h1D : 0) ^ fold;
      if (vld != 2'b00) m_cnt = (m_cnt == 15) ? 15 : m_cnt + 1;
      for (int c = 0; c < 2; c++) begin
        if (vld[c]) begin
          byte_v = int'(d[c*8 +: 8]);
          if (m_have[c] && byte_v != m_prev[c]) m_tog[c] = 1'b1;
          m_prev[c] = byte_v;
          m_have[c] = 1'b1;
        end
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, "_sig"}, 32'(bus.sig_out),     32'(m_sig));
    check({tag, "_tog"}, 32'(bus.toggle_seen), 32'(m_tog));
    check({tag, "_cnt"}, 32'(bus.vld_cnt),     32'(m_cnt));
  endtask

  // Drive one cycle, advance the model at the edge, compare 1 time unit later.
  task automatic step(input string tag, input logic en, input logic clr,
                      input logic [1:0] vld, input logic [15:0] d);
    bus.sink_en   = en;
    bus.sink_clr  = clr;
    bus.sink_vld  = vld;
    bus.sink_data = d;
    @(posedge clk);
    m_update(en, clr, vld, d);
    #1;
    check_model(tag);
  endtask

  logic [7:0] snap_sig;
  logic [1:0] snap_tog;
  logic [3:0] snap_cnt;

  initial begin
    rst = 1'b1;
    bus.sink_en = 1'b0;   bus.sink_clr = 1'b0;
    bus.sink_vld = '0;    bus.sink_data = '0;
    bus16.sink_en = 1'b0; bus16.sink_clr = 1'b0;
    bus16.sink_vld = '0;  bus16.sink_data = '0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_sig", 32'(bus.sig_out),     32'h0);
    check("reset_tog", 32'(bus.toggle_seen), 32'h0);
    check("reset_cnt", 32'(bus.vld_cnt),     32'h0);
    check("reset_sig16", 32'(bus16.sig_out), 32'h0);
    rst = 1'b0;

    // Basic MISR
    step("basic1", 1'b1, 1'b0, 2'b01, 16'h00A5);
    check("basic1_const", 32'(bus.sig_out), 32'hA5);
    step("basic2", 1'b1, 1'b0, 2'b01, 16'h00A5);
    check("basic2_const", 32'(bus.sig_out), 32'hF2);
    check("basic2_cnt",   32'(bus.vld_cnt), 32'h2);

    // Clear wins over enable, data not absorbed
    step("clr", 1'b1, 1'b1, 2'b01, 16'h0055);
    check("clr_sig", 32'(bus.sig_out), 32'h0);
    check("clr_cnt", 32'(bus.vld_cnt), 32'h0);
    step("postclr", 1'b1, 1'b0, 2'b01, 16'h00A5);
    check("postclr_sig", 32'(bus.sig_out),     32'hA5);
    check("postclr_tog", 32'(bus.toggle_seen), 32'h0);

    // Multi-channel fold
    step("mf_clr", 1'b0, 1'b1, 2'b00, 16'h0000);
    step("mf", 1'b1, 1'b0, 2'b11, 16'hF00F);
    check("mf_const", 32'(bus.sig_out), 32'hFF);

    // Toggle detection
    step("tg_clr", 1'b0, 1'b1, 2'b00, 16'h0000);
    step("tg1", 1'b1, 1'b0, 2'b01, 16'h0011);
    step("tg2", 1'b1, 1'b0, 2'b01, 16'h0011);
    step("tg3", 1'b1, 1'b0, 2'b00, 16'h0022);
    step("tg4", 1'b1, 1'b0, 2'b01, 16'h0011);
    check("tg_quiet", 32'(bus.toggle_seen), 32'h0);
    step("tg5", 1'b1, 1'b0, 2'b01, 16'h0033);
    check("tg_set", 32'(bus.toggle_seen), 32'h1);
    step("tg6", 1'b1, 1'b0, 2'b00, 16'h0044);
    check("tg_sticky", 32'(bus.toggle_seen), 32'h1);

    // Hold with enable low
    snap_sig = bus.sig_out; snap_tog = bus.toggle_seen; snap_cnt = bus.vld_cnt;
    for (int i = 0; i < 4; i++) begin
      step("hold", 1'b0, 1'b0, 2'($urandom), 16'($urandom));
    end
    check("hold_sig", 32'(bus.sig_out),     32'(snap_sig));
    check("hold_tog", 32'(bus.toggle_seen), 32'(snap_tog));
    check("hold_cnt", 32'(bus.vld_cnt),     32'(snap_cnt));
    // Captured prev_data must not have moved: same ch0 value gives no new flag.
    step("hold_clr", 1'b0, 1'b1, 2'b00, 16'h0000);
    step("hp1", 1'b1, 1'b0, 2'b01, 16'h0077);
    step("hp2", 1'b0, 1'b0, 2'b01, 16'h0099);
    step("hp3", 1'b1, 1'b0, 2'b01, 16'h0077);
    check("hold_prev", 32'(bus.toggle_seen), 32'h0);

    // X on an invalid channel
    step("xsafe1", 1'b1, 1'b0, 2'b01, {8'hxx, 8'h5A});
    step("xsafe2", 1'b1, 1'b0, 2'b01, {8'hxx, 8'h3C});
    check("xsafe_nox", 32'(^bus.sig_out ^ ^bus.toggle_seen ^ ^bus.vld_cnt) & 32'h1,
          32'(^(8'(m_sig)) ^ ^m_tog ^ ^(4'(m_cnt))));

    // Counter saturation
    step("sat_clr", 1'b0, 1'b1, 2'b00, 16'h0000);
    for (int i = 0; i < 20; i++) begin
      step("sat", 1'b1, 1'b0, 2'($urandom_range(1, 3)), 16'($urandom));
    end
    check("sat_cnt", 32'(bus.vld_cnt), 32'hF);

    // Wide channel split into chunks
    bus16.sink_en = 1'b1; bus16.sink_vld = 2'b01; bus16.sink_data = 32'h0000_1234;
    @(posedge clk);
    #1;
    bus16.sink_en = 1'b0;
    check("w16_sig", 32'(bus16.sig_out), 32'h26);
    check("w16_cnt", 32'(bus16.vld_cnt), 32'h1);

    // Asynchronous reset mid-cycle
    step("ar_clr", 1'b0, 1'b1, 2'b00, 16'h0000);
    step("ar_pre", 1'b1, 1'b0, 2'b01, 16'h00A5);
    bus.sink_en = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    m_reset();
    check("ar_sig", 32'(bus.sig_out),     32'h0);
    check("ar_tog", 32'(bus.toggle_seen), 32'h0);
    check("ar_cnt", 32'(bus.vld_cnt),     32'h0);
    #2;
    rst = 1'b0;
    step("ar_b1", 1'b1, 1'b0, 2'b01, 16'h00A5);
    check("ar_b1_const", 32'(bus.sig_out), 32'hA5);
    step("ar_b2", 1'b1, 1'b0, 2'b01, 16'h00A5);
    check("ar_b2_const", 32'(bus.sig_out), 32'hF2);
    check("ar_b2_cnt",   32'(bus.vld_cnt), 32'h2);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      step("rnd", ($urandom_range(0, 3) != 0), ($urandom_range(0, 24) == 0),
           2'($urandom), {8'($urandom_range(0, 3)), 8'($urandom_range(0, 3))});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
